// File: rtl/hex_entry_pkg.sv
// hex_entry_pkg: shared types and constants for the hex_entry block.
//   state_t  - controller state (EDIT: buffer editable, HOLD: word waiting on handshake)
//   NIB_W    - bits per hex digit
//   data_w() - word width for a given digit count
package hex_entry_pkg;

  typedef enum logic {
    EDIT = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NIB_W = 4;

  function automatic int data_w(input int digits);
    return NIB_W * digits;
  endfunction

endpackage

// File: rtl/rise_edge.sv
// rise_edge: single-cycle rising-edge qualifier for a debounced strobe.
//   clk   - system clock
//   rstn  - asynchronous active-low reset (clears history)
//   din   - debounced level input
//   pulse - high for the cycle in which din is 1 and its previous sample was 0
module rise_edge (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/hex_entry.sv
// hex_entry: keypad-style hex word editor with valid/ready commit port.
//   clk        - system clock
//   rstn       - asynchronous active-low reset
//   dig_pulse  - digit key strobe, dig_code sampled on its rising edge
//   dig_code   - hex value of pressed digit
//   del_pulse  - delete-last-digit strobe
//   ent_pulse  - commit strobe
//   out_data   - committed word
//   out_valid  - committed word available
//   out_ready  - consumer accepts out_data
//   disp_data  - live edit buffer for the display driver
//   digit_cnt  - digits currently in the buffer
//   err        - one-cycle pulse when a key is rejected
//
// state | meaning
// EDIT  | keys edit the buffer; ent with a non-empty buffer commits
// HOLD  | word offered on out_*; all keys rejected until accepted
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      dig_pulse,
  input  logic [NIB_W-1:0]          dig_code,
  input  logic                      del_pulse,
  input  logic                      ent_pulse,
  output logic [data_w(DIGITS)-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [data_w(DIGITS)-1:0] disp_data,
  output logic [CNT_W-1:0]          digit_cnt,
  output logic                      err
);

  localparam int               DATA_W  = data_w(DIGITS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DIGITS);

  logic dig_ev, del_ev, ent_ev, any_ev;

  rise_edge u_dig (.clk(clk), .rstn(rstn), .din(dig_pulse), .pulse(dig_ev));
  rise_edge u_del (.clk(clk), .rstn(rstn), .din(del_pulse), .pulse(del_ev));
  rise_edge u_ent (.clk(clk), .rstn(rstn), .din(ent_pulse), .pulse(ent_ev));

  assign any_ev = dig_ev | del_ev | ent_ev;

  state_t state_q, state_d;

  logic [DATA_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic nonempty, transfer;

  assign nonempty = (cnt_q != '0);
  assign transfer = ovalid_q & out_ready;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= EDIT;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EDIT:    if (ent_ev && nonempty) state_d = HOLD;
      HOLD:    if (transfer)           state_d = EDIT;
      default: state_d = EDIT;
    endcase
  end

  // next datapath/output values; ent > del > dig, lower ones drop silently
  always_comb begin
    disp_d   = disp_q;
    cnt_d    = cnt_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    err_d    = 1'b0;
    case (state_q)
      EDIT: begin
        if (ent_ev) begin
          if (nonempty) begin
            odata_d  = disp_q;
            ovalid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (del_ev) begin
          if (nonempty) begin
            disp_d = disp_q >> NIB_W;
            cnt_d  = cnt_q - CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else if (dig_ev) begin
          if (cnt_q < MAX_CNT) begin
            disp_d = {disp_q[DATA_W-NIB_W-1:0], dig_code};
            cnt_d  = cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // keys are rejected even on the transfer edge
        err_d = any_ev;
        if (transfer) begin
          ovalid_d = 1'b0;
          disp_d   = '0;
          cnt_d    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_q   <= '0;
      cnt_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      disp_q   <= disp_d;
      cnt_q    <= cnt_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  assign disp_data = disp_q;
  assign digit_cnt = cnt_q;
  assign out_data  = odata_q;
  assign out_valid = ovalid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hex_entry.sv
module tb_hex_entry;

  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dig_pulse, del_pulse, ent_pulse, out_ready;
  logic [3:0]  dig_code;
  logic [31:0] out_data, disp_data;
  logic        out_valid, err;
  logic [3:0]  digit_cnt;

  hex_entry #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rstn(rstn),
    .dig_pulse(dig_pulse), .dig_code(dig_code),
    .del_pulse(del_pulse), .ent_pulse(ent_pulse),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .disp_data(disp_data), .digit_cnt(digit_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int err_seen = 0;

  // reference model: digits as a list, newest last
  int          m_digs[$];
  bit          m_valid;
  logic [31:0] m_word;
  bit          m_err;
  bit          p_dig, p_del, p_ent;

  function automatic logic [31:0] m_disp();
    logic [31:0] r = 0;
    foreach (m_digs[i]) r = r * 16 + 32'(m_digs[i]);
    return r;
  endfunction

  task automatic m_reset();
    m_digs.delete();
    m_valid = 0; m_word = 0; m_err = 0;
    p_dig = 0; p_del = 0; p_ent = 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all();
    chk("err", 64'(err), 64'(m_err));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data", 64'(out_data), 64'(m_word));
    chk("disp_data", 64'(disp_data), 64'(m_disp()));
    chk("digit_cnt", 64'(digit_cnt), 64'(m_digs.size()));
  endtask

  // advance one clock, applying the spec rules to the current input levels
  task automatic cycle();
    bit de, le, ee;
    de = dig_pulse && !p_dig;
    le = del_pulse && !p_del;
    ee = ent_pulse && !p_ent;
    p_dig = dig_pulse; p_del = del_pulse; p_ent = ent_pulse;
    m_err = 0;
    if (m_valid) begin
      m_err = de || le || ee;
      if (out_ready) begin
        m_valid = 0;
        m_digs.delete();
      end
    end else if (ee) begin
      if (m_digs.size() > 0) begin
        m_word  = m_disp();
        m_valid = 1;
      end else m_err = 1;
    end else if (le) begin
      if (m_digs.size() > 0) void'(m_digs.pop_back());
      else m_err = 1;
    end else if (de) begin
      if (m_digs.size() < DIGITS) m_digs.push_back(int'(dig_code));
      else m_err = 1;
    end
    @(posedge clk); #1;
    if (err) err_seen++;
    chk_all();
  endtask

  task automatic press_dig(input logic [3:0] c);
    dig_pulse = 1; dig_code = c; cycle();
    dig_pulse = 0; cycle();
  endtask

  task automatic press_del();
    del_pulse = 1; cycle();
    del_pulse = 0; cycle();
  endtask

  task automatic press_ent();
    ent_pulse = 1; cycle();
    ent_pulse = 0; cycle();
  endtask

  int e0;

  initial begin
    dig_pulse = 0; del_pulse = 0; ent_pulse = 0; out_ready = 0; dig_code = 0;
    rstn = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_disp", 64'(disp_data), 64'h0);
    chk("rst_cnt", 64'(digit_cnt), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    rstn = 1;

    // enter 1,2,3
    e0 = err_seen;
    press_dig(4'h1); press_dig(4'h2); press_dig(4'h3);
    chk("d123_disp", 64'(disp_data), 64'h123);
    chk("d123_cnt", 64'(digit_cnt), 64'd3);
    chk("d123_noerr", 64'(err_seen - e0), 64'd0);

    // del, commit, hold 5 cycles, accept
    press_del();
    ent_pulse = 1; cycle(); ent_pulse = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_valid", 64'(out_valid), 64'h1);
      chk("hold_data", 64'(out_data), 64'h12);
    end
    out_ready = 1; cycle(); out_ready = 0;
    chk("xfer_valid", 64'(out_valid), 64'h0);
    chk("xfer_disp", 64'(disp_data), 64'h0);
    chk("xfer_cnt", 64'(digit_cnt), 64'h0);

    // overfill with F, then drain past empty
    e0 = err_seen;
    for (int i = 0; i < 9; i++) press_dig(4'hF);
    chk("full_disp", 64'(disp_data), 64'hFFFF_FFFF);
    chk("full_cnt", 64'(digit_cnt), 64'd8);
    chk("full_errs", 64'(err_seen - e0), 64'd1);
    for (int i = 0; i < 8; i++) press_del();
    del_pulse = 1; cycle();
    chk("empty_del_err", 64'(err), 64'h1);
    chk("empty_del_cnt", 64'(digit_cnt), 64'h0);
    del_pulse = 0; cycle();

    // held strobe counts once
    dig_pulse = 1; dig_code = 4'h5;
    repeat (20) cycle();
    dig_pulse = 0; cycle();
    chk("held_disp", 64'(disp_data), 64'h5);
    chk("held_cnt", 64'(digit_cnt), 64'd1);

    // ent and dig on one edge: commit wins, dig dropped silently
    ent_pulse = 1; dig_pulse = 1; dig_code = 4'h7; cycle();
    chk("coinc_valid", 64'(out_valid), 64'h1);
    chk("coinc_data", 64'(out_data), 64'h5);
    chk("coinc_err", 64'(err), 64'h0);
    ent_pulse = 0; dig_pulse = 0; cycle();

    // key in HOLD is rejected
    dig_pulse = 1; dig_code = 4'hA; cycle();
    chk("hold_key_err", 64'(err), 64'h1);
    chk("hold_key_disp", 64'(disp_data), 64'h5);
    chk("hold_key_data", 64'(out_data), 64'h5);
    dig_pulse = 0; cycle();

    // async reset between edges drops the pending word
    rstn = 0;
    #2;
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_cnt", 64'(digit_cnt), 64'h0);
    chk("arst_disp", 64'(disp_data), 64'h0);
    #1 rstn = 1;
    m_reset();

    // ent on empty buffer
    ent_pulse = 1; cycle();
    chk("empty_ent_err", 64'(err), 64'h1);
    chk("empty_ent_valid", 64'(out_valid), 64'h0);
    ent_pulse = 0; cycle();
    press_dig(4'h9);
    chk("after_empty_ent_cnt", 64'(digit_cnt), 64'd1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      dig_pulse = ($urandom_range(0, 2) == 0);
      del_pulse = ($urandom_range(0, 5) == 0);
      ent_pulse = ($urandom_range(0, 7) == 0);
      dig_code  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
